// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store unit between ex_mem and mem_wb with a req/gnt/rvalid data-bus port
//
// Optional feature: define MEM_LSU_MISALIGN_EXC_EN to raise an exception on misaligned or
// oversize accesses. When it is undefined, the offset is silently aligned down to the access size.
//
// Ports:
//   clk, rst                      clock and asynchronous active-low reset
//   req_valid_i / req_ready_o     operation handshake carrying op_i, addr_i, wdata_i and rd_addr_i
//   flush_i                       kill the in-flight operation (interrupt entry)
//   bus_req_o .. bus_wdata_o      registered request; held until bus_gnt_i
//   bus_gnt_i, bus_rvalid_i,
//   bus_rdata_i, bus_err_i        grant and response; one transaction outstanding
//   wb_valid_o .. wb_data_o       one-cycle completion pulse with extended load data
//   exc_valid_o .. exc_addr_o     one-cycle exception pulse with cause and original address
module mem_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W/8-1:0] bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_err_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              exc_valid_o,
    output logic [1:0]        exc_cause_o,
    output logic [ADDR_W-1:0] exc_addr_o
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam logic [1:0] MAX_SZ = 2'(OW);
    localparam int CW = $clog2(TIMEOUT + 2);
`ifdef MEM_LSU_MISALIGN_EXC_EN
    localparam bit MIS_EXC = 1'b1;
`else
    localparam bit MIS_EXC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic              st_q, st_d, uns_q, uns_d, kill_q, kill_d;
    logic [1:0]        size_q, size_d;
    logic [OW-1:0]     off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [NB-1:0]     bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              exc_valid_q, exc_valid_d;
    logic [1:0]        exc_cause_q, exc_cause_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

    logic              oversize, misaligned, accept, tmo, sgn;
    logic [1:0]        esz;
    logic [OW-1:0]     off, amask, aoff;
    logic [NB-1:0]     bmask;
    logic [DATA_W-1:0] rshift, kmask, ld_ext;

    always_comb begin
        // Oversize accesses are clamped to the beat width so lane math stays in range.
        oversize   = op_i[1:0] > MAX_SZ;
        esz        = oversize ? MAX_SZ : op_i[1:0];
        off        = addr_i[OW-1:0];
        amask      = OW'((1 << esz) - 1);
        aoff       = off & ~amask;
        misaligned = oversize || ((off & amask) != '0);
        bmask      = NB'(esz == 2'd0 ? 8'h01 : esz == 2'd1 ? 8'h03 : esz == 2'd2 ? 8'h0F : 8'hFF);
        accept     = (state_q == IDLE) && req_valid_i && !flush_i;
        tmo        = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
        // kmask keeps the access-size bits; its top set bit selects the sign bit.
        rshift     = bus_rdata_i >> {off_q, 3'b000};
        kmask      = ~({DATA_W{1'b1}} << (8 << size_q));
        sgn        = !uns_q && |(rshift & kmask & ~(kmask >> 1));
        ld_ext     = (rshift & kmask) | (sgn ? ~kmask : '0);
    end

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        uns_d       = uns_q;
        kill_d      = kill_q;
        size_d      = size_q;
        off_d       = off_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = wb_we_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        unique case (state_q)
            IDLE: if (accept) begin
                st_d   = op_i[3];
                uns_d  = op_i[2];
                size_d = esz;
                off_d  = aoff;
                addr_d = addr_i;
                rd_d   = rd_addr_i;
                kill_d = 1'b0;
                if (MIS_EXC && misaligned) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = {1'b0, op_i[3]};
                    exc_addr_d  = addr_i;
                end else begin
                    state_d     = REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = op_i[3];
                    bus_addr_d  = {addr_i[ADDR_W-1:OW], {OW{1'b0}}};
                    bus_be_d    = bmask << aoff;
                    bus_wdata_d = wdata_i << {aoff, 3'b000};
                end
            end
            REQ: if (bus_gnt_i) begin
                // Once granted the slave owes a response, so a flush only marks the result dead.
                state_d   = WAIT;
                bus_req_d = 1'b0;
                kill_d    = flush_i;
                cnt_d     = '0;
            end else if (flush_i) begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
            WAIT: begin
                cnt_d  = cnt_q + 1'b1;
                kill_d = kill_q || flush_i;
                if (bus_rvalid_i || tmo) begin
                    state_d = IDLE;
                    if (!(kill_q || flush_i)) begin
                        if (bus_rvalid_i && !bus_err_i) begin
                            wb_valid_d = 1'b1;
                            wb_we_d    = !st_q;
                            wb_addr_d  = rd_q;
                            wb_data_d  = st_q ? '0 : ld_ext;
                        end else begin
                            exc_valid_d = 1'b1;
                            exc_cause_d = {1'b1, st_q};
                            exc_addr_d  = addr_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            st_q        <= 1'b0;
            uns_q       <= 1'b0;
            kill_q      <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            addr_q      <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            uns_q       <= uns_d;
            kill_q      <= kill_d;
            size_q      <= size_d;
            off_q       <= off_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_we_o     = wb_we_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign exc_valid_o = exc_valid_q;
    assign exc_cause_o = exc_cause_q;
    assign exc_addr_o  = exc_addr_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard testbench for mem_lsu (32-bit with TIMEOUT=4, plus a 64-bit instance)
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, flush = 0, gnt = 0, rvalid = 0, err = 0;
    logic [3:0]  op = 0;
    logic [31:0] addr = 0, wdata = 0, rdata = 0;
    logic [4:0]  rd = 0;
    logic        req_ready, bus_req, bus_we, wb_valid, wb_we, exc_valid;
    logic [31:0] bus_addr, bus_wdata, wb_data, exc_addr;
    logic [3:0]  bus_be;
    logic [4:0]  wb_addr;
    logic [1:0]  exc_cause;

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .op_i(op),
        .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd), .flush_i(flush), .bus_req_o(bus_req),
        .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
        .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata), .bus_err_i(err),
        .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .exc_valid_o(exc_valid), .exc_cause_o(exc_cause), .exc_addr_o(exc_addr)
    );

    logic        rv64 = 0, g64 = 0, rvl64 = 0;
    logic [3:0]  op64 = 0;
    logic [31:0] ad64 = 0;
    logic [63:0] rdata64 = 0;
    logic        ready64, breq64, bwe64, wbv64, wbwe64, excv64;
    logic [31:0] baddr64, excaddr64;
    logic [7:0]  bbe64;
    logic [63:0] bwdata64, wbdata64;
    logic [4:0]  wbaddr64;
    logic [1:0]  exccause64;

    mem_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
        .clk(clk), .rst(rst), .req_valid_i(rv64), .req_ready_o(ready64), .op_i(op64),
        .addr_i(ad64), .wdata_i(64'd0), .rd_addr_i(5'd7), .flush_i(1'b0), .bus_req_o(breq64),
        .bus_we_o(bwe64), .bus_addr_o(baddr64), .bus_be_o(bbe64), .bus_wdata_o(bwdata64),
        .bus_gnt_i(g64), .bus_rvalid_i(rvl64), .bus_rdata_i(rdata64), .bus_err_i(1'b0),
        .wb_valid_o(wbv64), .wb_we_o(wbwe64), .wb_addr_o(wbaddr64), .wb_data_o(wbdata64),
        .exc_valid_o(excv64), .exc_cause_o(exccause64), .exc_addr_o(excaddr64)
    );

    typedef struct packed {
        logic        exc;
        logic [1:0]  cause;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e_m, g_m;
    int n_checks = 0;
    int n_fail = 0;

    // Every wb/exc pulse of the 32-bit unit is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst && (wb_valid || exc_valid)) begin
            n_checks++;
            g_m = exc_valid ? {1'b1, exc_cause, 1'b0, 5'd0, exc_addr}
                            : {1'b0, 2'd0, wb_we, wb_we ? wb_addr : 5'd0, wb_we ? wb_data : 32'd0};
            if (wb_valid && exc_valid) begin
                n_fail++;
                $display("FAIL pulse_overlap wb_valid=1 exc_valid=1, required at most one");
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result got %h, required no output", g_m);
            end else begin
                e_m = sb.pop_front();
                if (g_m !== e_m) begin
                    n_fail++;
                    $display("FAIL result got %h, required %h", g_m, e_m);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Starts one cycle after an active edge; returns in the cycle the result should appear.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                          input logic [4:0] r, input int gwait, input logic [31:0] rdat,
                          input logic e, output logic [3:0] be, output logic [31:0] bw,
                          output logic [31:0] ba, output logic bwe, output logic held);
        req_valid = 1; op = o; addr = a; wdata = w; rd = r;
        @(posedge clk); #1;
        req_valid = 0;
        be = bus_be; bw = bus_wdata; ba = bus_addr; bwe = bus_we; held = bus_req;
        repeat (gwait) begin
            @(posedge clk); #1;
            held &= bus_req && (bus_be == be) && (bus_addr == ba);
        end
        gnt = 1;
        @(posedge clk); #1;
        gnt = 0;
        held &= !bus_req;
        rvalid = 1; rdata = rdat; err = e;
        @(posedge clk); #1;
        rvalid = 0; err = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, wb_valid, wb_we, wb_addr, wb_data,
             exc_valid, exc_cause, exc_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got bus_req=%b wb_valid=%b exc_valid=%b be=%b, required all 0",
                     bus_req, wb_valid, exc_valid, bus_be);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b, required 1", req_ready);
        end
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte();
        logic [3:0] be; logic [31:0] bw, ba; logic bwe, held;
        sb.push_back('{1'b0, 2'd0, 1'b1, 5'd3, 32'hFFFF_FF80});
        run_op(4'b0000, 32'h1003, 32'h0, 5'd3, 0, 32'h80FF_1234, 1'b0, be, bw, ba, bwe, held);
        n_checks++;
        if (be !== 4'b1000 || ba !== 32'h1000 || bwe !== 1'b0 || held !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_bus got be=%b addr=%h we=%b held=%b, required be=1000 addr=00001000 we=0 held=1",
                     be, ba, bwe, held);
        end
        n_checks++;
        if (wb_valid !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_latency got wb_valid=%b req_ready=%b at T+3, required 1 1", wb_valid, req_ready);
        end
        sb.push_back('{1'b0, 2'd0, 1'b1, 5'd4, 32'h0000_0080});
        run_op(4'b0100, 32'h1003, 32'h0, 5'd4, 0, 32'h80FF_1234, 1'b0, be, bw, ba, bwe, held);
        n_checks++;
        if (wb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lbu_latency got wb_valid=%b, required 1", wb_valid);
        end
    endtask

    task automatic test_store_half();
        logic [3:0] be; logic [31:0] bw, ba; logic bwe, held;
        sb.push_back('{1'b0, 2'd0, 1'b0, 5'd0, 32'h0});
        run_op(4'b1001, 32'h2002, 32'h0000_BEEF, 5'd1, 1, 32'h0, 1'b0, be, bw, ba, bwe, held);
        n_checks++;
        if (be !== 4'b1100 || bw !== 32'hBEEF_0000 || ba !== 32'h2000 || bwe !== 1'b1 || held !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_bus got be=%b wdata=%h addr=%h we=%b held=%b, required 1100 beef0000 00002000 1 1",
                     be, bw, ba, bwe, held);
        end
        n_checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_wb got wb_valid=%b wb_we=%b, required 1 0", wb_valid, wb_we);
        end
    endtask

    task automatic test_misaligned();
`ifdef MEM_LSU_MISALIGN_EXC_EN
        logic quiet;
        sb.push_back('{1'b1, 2'd0, 1'b0, 5'd0, 32'h3001});
        req_valid = 1; op = 4'b0010; addr = 32'h3001; rd = 5'd2;
        @(posedge clk); #1;
        req_valid = 0;
        n_checks++;
        if (exc_valid !== 1'b1 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_misaligned got exc_valid=%b bus_req=%b at T+1, required 1 0", exc_valid, bus_req);
        end
        quiet = 1;
        repeat (2) begin
            @(posedge clk); #1;
            quiet &= !bus_req;
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_misaligned_nobus got bus_req activity, required none");
        end
`else
        logic [3:0] be; logic [31:0] bw, ba; logic bwe, held;
        sb.push_back('{1'b0, 2'd0, 1'b1, 5'd2, 32'hDEAD_BEEF});
        run_op(4'b0010, 32'h3001, 32'h0, 5'd2, 0, 32'hDEAD_BEEF, 1'b0, be, bw, ba, bwe, held);
        n_checks++;
        if (ba !== 32'h3000 || be !== 4'hF) begin
            n_fail++;
            $display("FAIL lw_misaligned_legacy got addr=%h be=%h, required 00003000 f", ba, be);
        end
`endif
    endtask

    task automatic test_bus_error();
        logic [3:0] be; logic [31:0] bw, ba; logic bwe, held;
        sb.push_back('{1'b1, 2'd3, 1'b0, 5'd0, 32'h4000});
        run_op(4'b1010, 32'h4000, 32'h1234_5678, 5'd0, 3, 32'h0, 1'b1, be, bw, ba, bwe, held);
        n_checks++;
        if (held !== 1'b1 || exc_valid !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_bus_err got held=%b exc_valid=%b wb_valid=%b, required 1 1 0", held, exc_valid, wb_valid);
        end
        sb.push_back('{1'b1, 2'd2, 1'b0, 5'd0, 32'h4004});
        run_op(4'b0010, 32'h4004, 32'h0, 5'd5, 0, 32'h0, 1'b1, be, bw, ba, bwe, held);
        n_checks++;
        if (exc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_bus_err got exc_valid=%b, required 1", exc_valid);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        sb.push_back('{1'b1, 2'd2, 1'b0, 5'd0, 32'h5000});
        req_valid = 1; op = 4'b0010; addr = 32'h5000; rd = 5'd6;
        @(posedge clk); #1;
        req_valid = 0; gnt = 1;
        @(posedge clk); #1;
        gnt = 0;
        while (!exc_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL timeout_cycles got %0d, required 4", n);
        end
        rvalid = 1; rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rvalid = 0;
        n_checks++;
        if (wb_valid !== 1'b0 || exc_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_rvalid got wb_valid=%b exc_valid=%b req_ready=%b, required 0 0 1",
                     wb_valid, exc_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        logic busy;
        req_valid = 1; flush = 1; op = 4'b0010; addr = 32'h6000; rd = 5'd8;
        @(posedge clk); #1;
        req_valid = 0; flush = 0;
        n_checks++;
        if (bus_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle got bus_req=%b req_ready=%b, required 0 1", bus_req, req_ready);
        end
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0; flush = 1;
        @(posedge clk); #1;
        flush = 0;
        n_checks++;
        if (bus_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_req got bus_req=%b req_ready=%b, required 0 1", bus_req, req_ready);
        end
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0; gnt = 1;
        @(posedge clk); #1;
        gnt = 0; flush = 1;
        @(posedge clk); #1;
        flush = 0;
        busy = !req_ready;
        @(posedge clk); #1;
        busy &= !req_ready;
        rvalid = 1; rdata = 32'h1111_2222;
        @(posedge clk); #1;
        rvalid = 0;
        n_checks++;
        if (busy !== 1'b1 || wb_valid !== 1'b0 || exc_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_wait got busy=%b wb_valid=%b exc_valid=%b req_ready=%b, required 1 0 0 1",
                     busy, wb_valid, exc_valid, req_ready);
        end
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0; gnt = 1; flush = 1;
        @(posedge clk); #1;
        gnt = 0; flush = 0; rvalid = 1; err = 1;
        @(posedge clk); #1;
        rvalid = 0; err = 0;
        n_checks++;
        if (wb_valid !== 1'b0 || exc_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_gnt got wb_valid=%b exc_valid=%b req_ready=%b, required 0 0 1",
                     wb_valid, exc_valid, req_ready);
        end
    endtask

    task automatic test_mid_reset();
        req_valid = 1; op = 4'b0010; addr = 32'h7000; rd = 5'd9;
        @(posedge clk); #1;
        req_valid = 0;
        #2 rst = 0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset got bus_req=%b req_ready=%b, required 0 1", bus_req, req_ready);
        end
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] be; logic [31:0] bw, ba; logic bwe, held;
        sb.push_back('{1'b0, 2'd0, 1'b1, 5'd9, 32'hFFFF_8001});
        run_op(4'b0001, 32'h5002, 32'h0, 5'd9, 0, 32'h8001_7FFF, 1'b0, be, bw, ba, bwe, held);
        n_checks++;
        if (req_ready !== 1'b1 || be !== 4'b1100) begin
            n_fail++;
            $display("FAIL lh_ready got req_ready=%b be=%b, required 1 1100", req_ready, be);
        end
        sb.push_back('{1'b0, 2'd0, 1'b1, 5'd10, 32'h0000_7FFF});
        run_op(4'b0101, 32'h5000, 32'h0, 5'd10, 0, 32'h8001_7FFF, 1'b0, be, bw, ba, bwe, held);
        n_checks++;
        if (wb_valid !== 1'b1 || be !== 4'b0011) begin
            n_fail++;
            $display("FAIL lhu_b2b got wb_valid=%b be=%b, required 1 0011", wb_valid, be);
        end
        sb.push_back('{1'b0, 2'd0, 1'b0, 5'd0, 32'h0});
        run_op(4'b1000, 32'h6001, 32'h0000_00AB, 5'd0, 0, 32'h0, 1'b0, be, bw, ba, bwe, held);
        n_checks++;
        if (be !== 4'b0010 || bw !== 32'h0000_AB00 || wb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_b2b got be=%b wdata=%h wb_valid=%b, required 0010 0000ab00 1", be, bw, wb_valid);
        end
    endtask

    task automatic test_dw64();
        logic [3:0]  ops [3]  = '{4'b0011, 4'b0110, 4'b0010};
        logic [31:0] ads [3]  = '{32'h10, 32'h14, 32'h14};
        logic [7:0]  bes [3]  = '{8'hFF, 8'hF0, 8'hF0};
        logic [63:0] exps [3] = '{64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001};
        logic [7:0]  be;
        for (int i = 0; i < 3; i++) begin
            rv64 = 1; op64 = ops[i]; ad64 = ads[i];
            @(posedge clk); #1;
            rv64 = 0; be = bbe64; g64 = 1;
            @(posedge clk); #1;
            g64 = 0; rvl64 = 1; rdata64 = 64'h8000_0001_1234_5678;
            @(posedge clk); #1;
            rvl64 = 0;
            n_checks++;
            if (be !== bes[i] || wbv64 !== 1'b1 || wbdata64 !== exps[i]) begin
                n_fail++;
                $display("FAIL dw64_op%0d got be=%h wb_valid=%b data=%h, required be=%h 1 data=%h",
                         i, be, wbv64, wbdata64, bes[i], exps[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_flush();
        test_mid_reset();
        test_back_to_back();
        test_dw64();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending results, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised, multi-cycle load/store unit that replaces the single-cycle combinational memory stage between ex_mem and mem_wb. It accepts one memory operation at a time over a valid/ready handshake and generates byte strobes and lane-shifted store data. It drives a request/grant/response data-bus port with one transaction outstanding, then returns sign/zero-extended load data or a store completion to writeback. Misaligned accesses, bus errors and bus timeouts are reported as exceptions. A flush input supports interrupt entry.

## Interface
- DATA_W, 32: data/register width, 32 or 64; bytes per beat NB = DATA_W/8, offset width OW = log2(NB).
- ADDR_W, 32: byte-address width.
- TIMEOUT, 255: maximum cycles in WAIT before a fault; 0 disables the timeout.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  operation valid.
- req_ready_o  out  1  unit can accept.
- op_i  in  4  [3] store, [2] unsigned load, [1:0] size (0 B, 1 H, 2 W, 3 D).
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  store data, right-aligned.
- rd_addr_i  in  5  load destination register.
- flush_i  in  1  kill the in-flight operation.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  write.
- bus_addr_o  out  ADDR_W  beat-aligned address (low OW bits zero).
- bus_be_o  out  NB  byte enables.
- bus_wdata_o  out  DATA_W  lane-shifted store data.
- bus_gnt_i  in  1  request accepted.
- bus_rvalid_i  in  1  response (load data or store ack).
- bus_rdata_i  in  DATA_W  load beat.
- bus_err_i  in  1  error, qualified by bus_rvalid_i.
- wb_valid_o  out  1  one-cycle completion pulse.
- wb_we_o  out  1  register write (loads only).
- wb_addr_o  out  5  destination register.
- wb_data_o  out  DATA_W  extended load data.
- exc_valid_o  out  1  one-cycle exception pulse.
- exc_cause_o  out  2  0 load misaligned, 1 store misaligned, 2 load fault, 3 store fault.
- exc_addr_o  out  ADDR_W  faulting address (original addr_i).

## Operation
- States: IDLE, REQ, WAIT. req_ready_o = (state == IDLE).
- Accept in IDLE: capture op, addr, wdata and rd_addr; compute offset = addr[OW-1:0].
  - Misaligned (offset not a multiple of 1<<size), or size above log2(NB): handled per Configuration.
  - Otherwise go to REQ.
- REQ: bus_req_o=1 with stable registered bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o. Leave on bus_gnt_i for WAIT.
- Byte enables: ((1<<(1<<size))-1) << offset.
- Store data: wdata_i << (8*offset).
- WAIT: on bus_rvalid_i go to IDLE and drive one cycle of the result.
  - No error: wb_valid_o=1 and wb_we_o=~store. Load data is bus_rdata_i >> (8*offset), truncated to the access size, then sign-extended (op[2]=0) or zero-extended (op[2]=1) to DATA_W.
  - bus_err_i: exc_valid_o=1 with cause 2 or 3. No wb_valid_o.
- Timeout: a counter clears on entry to WAIT. On reaching TIMEOUT, raise the fault exception and go to IDLE. A later stray bus_rvalid_i is ignored.
- flush_i:
  - In IDLE: the same-cycle request is not accepted.
  - In REQ without bus_gnt_i: drop the request and go to IDLE.
  - In REQ with bus_gnt_i, or in WAIT: set a kill flag, still wait for bus_rvalid_i, and suppress wb_valid_o and exc_valid_o.
- wb_valid_o and exc_valid_o are never both 1.

## Timing
- Reset: state IDLE, all outputs 0, counter and kill flag 0.
- Load with immediate grant and next-cycle response: accept at T, bus_req_o at T+1, gnt at T+1, rvalid at T+2, wb_valid_o at T+3.
- req_ready_o is 1 again in the wb_valid_o cycle, so the maximum rate is one operation every 3 cycles.
- Misaligned exception (macro on): accept at T, exc_valid_o at T+1, no bus_req_o.
- Bus outputs change only on state entry. bus_req_o is held until grant.
- Reset asserted mid-transaction returns to IDLE immediately. The bus slave is reset on the same domain.

## Configuration
- MEM_LSU_MISALIGN_EXC_EN defined: misaligned or oversize operations raise exc_valid_o with cause 0 or 1, exc_addr_o = addr_i, and issue no bus access.
- Undefined: offset is truncated to the access-size alignment (addr & ~((1<<size)-1)) and the access proceeds normally with no exception. This is legacy silent behaviour.

## Test plan
- LB, DATA_W=32, addr 0x1003, rdata 0x80FF_1234 -> bus_be_o 4'b1000, wb_data_o 0xFFFF_FF80. LBU on the same beat -> 0x0000_0080.
- SH, addr 0x2002, wdata 0x0000_BEEF -> bus_be_o 4'b1100, bus_wdata_o 0xBEEF_0000, wb_valid_o with wb_we_o=0.
- LW, addr 0x3001, macro on -> exc_valid_o at T+1, cause 0, exc_addr_o 0x3001, bus_req_o stays 0. Macro off -> bus_addr_o 0x3000, be 4'hF.
- Grant withheld for 3 cycles, then rvalid with bus_err_i on SW -> exc cause 3, no wb_valid_o. TIMEOUT=4 with no rvalid -> cause 2 or 3 after 4 WAIT cycles.
- flush_i in the WAIT cycle of an LW -> no wb_valid_o or exc_valid_o. req_ready_o returns only after rvalid.
- DATA_W=64, LD at addr 0x10, then LWU at 0x14 with rdata 0x8000_0001_xxxx_xxxx -> wb_data_o 0x0000_0000_8000_0001.
